// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects and strobes.
module multicycle_ctrl_fsm #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic        branch_taken,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic [2:0]  imm_sel,
   output logic [1:0]  alu_src_a,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        instr_retired,
   output logic        illegal,
   output logic        bus_err,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // Last wait cycle index: a missing ready here ends the access with an error.
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   logic [6:0] opc;
   logic       is_load, is_store, is_branch, is_jal, is_jalr, legal, rd_nz, timeout;
   logic [2:0] imm_fmt;
   logic [1:0] asa_dec, aop_dec;
   logic       asb_dec;
   logic       req_c, we_c, irw_c, pcw_c, rw_c, ret_c;
   logic       unused_inst;

   assign opc       = inst[6:0];
   assign rd_nz     = (inst[11:7] != 5'd0);
   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign is_branch = (opc == OPC_BRANCH);
   assign is_jal    = (opc == OPC_JAL);
   assign is_jalr   = (opc == OPC_JALR);
   assign timeout   = (cnt_q == CNT_LIMIT);
   assign unused_inst = ^inst[31:12];

   always_comb begin
      legal   = 1'b1;
      imm_fmt = 3'd0;
      asa_dec = 2'd0;
      asb_dec = 1'b0;
      aop_dec = 2'd0;
      case (opc)
         OPC_LUI:    begin imm_fmt = 3'd4; asa_dec = 2'd2; asb_dec = 1'b1; end
         OPC_AUIPC:  begin imm_fmt = 3'd4; asa_dec = 2'd1; asb_dec = 1'b1; end
         OPC_JAL:    imm_fmt = 3'd3;
         OPC_JALR:   begin imm_fmt = 3'd0; asb_dec = 1'b1; end
         OPC_BRANCH: imm_fmt = 3'd2;
         OPC_LOAD:   begin imm_fmt = 3'd0; asb_dec = 1'b1; end
         OPC_STORE:  begin imm_fmt = 3'd1; asb_dec = 1'b1; end
         OPC_OPIMM:  begin imm_fmt = 3'd0; asb_dec = 1'b1; aop_dec = 2'd2; end
         OPC_OP:     aop_dec = 2'd1;
         default:    legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      st_d         = st_q;
      cnt_d        = cnt_q;
      illegal_d    = illegal_q;
      bus_err_d    = bus_err_q;
      req_c        = 1'b0;
      we_c         = 1'b0;
      irw_c        = 1'b0;
      pcw_c        = 1'b0;
      rw_c         = 1'b0;
      ret_c        = 1'b0;
      mem_addr_sel = 1'b0;
      pc_sel       = 2'd0;
      wb_sel       = 2'd0;
      imm_sel      = (st_q == S_FETCH) ? 3'd0 : imm_fmt;
      alu_src_a    = 2'd0;
      alu_src_b    = 1'b0;
      alu_op       = 2'd0;

      // ALU operands stay stable from EXEC through MEM/WB so results stay valid.
      if (st_q == S_EXEC || st_q == S_MEM || st_q == S_WB) begin
         alu_src_a = asa_dec;
         alu_src_b = asb_dec;
         alu_op    = aop_dec;
      end

      case (st_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               irw_c = 1'b1;
               st_d  = S_DECODE;
            end else if (timeout) begin
               bus_err_d = 1'b1;
               st_d      = S_HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DECODE: begin
            if (!legal) begin
               illegal_d = 1'b1;
               st_d      = S_HALT;
            end else begin
               st_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_branch) begin
               pcw_c  = 1'b1;
               pc_sel = branch_taken ? 2'd1 : 2'd0;
               ret_c  = 1'b1;
               st_d   = S_FETCH;
            end else if (is_load || is_store) begin
               st_d = S_MEM;
            end else begin
               st_d = S_WB;
            end
         end
         S_MEM: begin
            req_c        = 1'b1;
            mem_addr_sel = 1'b1;
            we_c         = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  pcw_c = 1'b1;
                  ret_c = 1'b1;
                  st_d  = S_FETCH;
               end else begin
                  st_d = S_WB;
               end
            end else if (timeout) begin
               bus_err_d = 1'b1;
               st_d      = S_HALT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            rw_c   = rd_nz;
            wb_sel = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
            pcw_c  = 1'b1;
            pc_sel = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
            ret_c  = 1'b1;
            st_d   = S_FETCH;
         end
         S_HALT: st_d = S_HALT;
         default: st_d = S_HALT;
      endcase

      if (st_d != st_q) cnt_d = '0;
   end

   // Strobes are gated by rst_n so nothing escapes while reset is held.
   assign mem_req       = req_c & rst_n;
   assign mem_we        = we_c  & rst_n;
   assign ir_write      = irw_c & rst_n;
   assign pc_write      = pcw_c & rst_n;
   assign reg_write     = rw_c  & rst_n;
   assign instr_retired = ret_c & rst_n;
   assign illegal       = illegal_q;
   assign bus_err       = bus_err_q;
   assign state         = st_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed instruction sequences
// push per-cycle expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst;
   logic        mem_ready, branch_taken;
   logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
   logic [1:0]  pc_sel;
   logic [2:0]  imm_sel;
   logic [1:0]  alu_src_a;
   logic        alu_src_b;
   logic [1:0]  alu_op;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        instr_retired, illegal, bus_err;
   logic [2:0]  state;

   multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .mem_ready(mem_ready),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write),
      .pc_sel(pc_sel), .imm_sel(imm_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
      .wb_sel(wb_sel), .instr_retired(instr_retired), .illegal(illegal),
      .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] LW    = 32'h0000A103;
   localparam logic [31:0] BEQ   = 32'hFE000EE3;
   localparam logic [31:0] JAL   = 32'h008000EF;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] JALR  = 32'h000080E7;
   localparam logic [31:0] LUI   = 32'h123450B7;
   localparam logic [31:0] AUIPC = 32'h00001097;
   localparam logic [31:0] ADD   = 32'h002081B3;
   localparam logic [31:0] SW    = 32'h0020A023;
   localparam logic [31:0] BAD   = 32'h0000007F;

   // Strobe vector order: {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, instr_retired}
   localparam logic [6:0] SB_0    = 7'b0000000;
   localparam logic [6:0] SB_F    = 7'b1001000;
   localparam logic [6:0] SB_FW   = 7'b1000000;
   localparam logic [6:0] SB_RET  = 7'b0000111;
   localparam logic [6:0] SB_RET0 = 7'b0000101;
   localparam logic [6:0] SB_ML   = 7'b1010000;
   localparam logic [6:0] SB_MS   = 7'b1110000;
   localparam logic [6:0] SB_MSR  = 7'b1110101;

   typedef struct {
      string      nm;
      int         st;
      logic [6:0] stb;
      logic [1:0] fl;   // {illegal, bus_err}
      int         pcs, imm, asa, asb, aop, wbs;  // -1 = not checked
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic exp_t mk(string nm, int st, logic [6:0] stb, logic [1:0] fl,
                               int pcs, int imm, int asa, int asb, int aop, int wbs);
      exp_t e;
      e.nm = nm; e.st = st; e.stb = stb; e.fl = fl;
      e.pcs = pcs; e.imm = imm; e.asa = asa; e.asb = asb; e.aop = aop; e.wbs = wbs;
      return e;
   endfunction

   task automatic chk(input string nm, input string fld, input int act, input int exp);
      if (exp >= 0 && act != exp) begin
         miscompares++;
         $display("FAIL %s.%s: got %0d, want %0d", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         cur = q.pop_front();
         vectors++;
         chk(cur.nm, "state",   int'(state), cur.st);
         chk(cur.nm, "strobes", int'({mem_req, mem_we, mem_addr_sel, ir_write,
                                      pc_write, reg_write, instr_retired}), int'(cur.stb));
         chk(cur.nm, "flags",   int'({illegal, bus_err}), int'(cur.fl));
         chk(cur.nm, "pc_sel",  int'(pc_sel), cur.pcs);
         chk(cur.nm, "imm_sel", int'(imm_sel), cur.imm);
         chk(cur.nm, "alu_src_a", int'(alu_src_a), cur.asa);
         chk(cur.nm, "alu_src_b", int'(alu_src_b), cur.asb);
         chk(cur.nm, "alu_op",  int'(alu_op), cur.aop);
         chk(cur.nm, "wb_sel",  int'(wb_sel), cur.wbs);
      end
   end

   task automatic step(input logic [31:0] i, input logic rdy, input logic br, input exp_t e);
      inst = i; mem_ready = rdy; branch_taken = br;
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   // Four-cycle F/D/E/WB instruction with mem_ready high on the first request.
   task automatic run4(input string nm, input logic [31:0] i, input int imm,
                       input int asa, input int asb, input int aop,
                       input int wbs, input int pcs, input logic rdnz, input logic wb_alu);
      step(i, 1'b1, 1'b0, mk({nm, "_f"}, 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(i, 1'b1, 1'b0, mk({nm, "_d"}, 1, SB_0, 2'b00, -1, imm, -1, -1, -1, -1));
      step(i, 1'b1, 1'b0, mk({nm, "_e"}, 2, SB_0, 2'b00, -1, imm, asa, asb, aop, -1));
      step(i, 1'b1, 1'b0, mk({nm, "_wb"}, 4, rdnz ? SB_RET : SB_RET0, 2'b00, pcs, imm,
                             wb_alu ? asa : -1, wb_alu ? asb : -1, wb_alu ? aop : -1, wbs));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; inst = ADDI; mem_ready = 1'b1; branch_taken = 1'b0;
      @(posedge clk); #1;
      step(ADDI, 1'b1, 1'b0, mk("rst_hold0", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("rst_hold1", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      rst_n = 1'b1;

      run4("addi", ADDI, 0, 0, 1, 2, 0, 0, 1'b1, 1'b0);

      // Load with three wait cycles in MEM, retires in cycle 8
      step(LW, 1'b1, 1'b0, mk("lw_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(LW, 1'b1, 1'b0, mk("lw_d", 1, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      step(LW, 1'b1, 1'b0, mk("lw_e", 2, SB_0, 2'b00, -1, 0, 0, 1, 0, -1));
      for (int k = 0; k < 3; k++)
         step(LW, 1'b0, 1'b0, mk("lw_mwait", 3, SB_ML, 2'b00, -1, 0, 0, 1, 0, -1));
      step(LW, 1'b1, 1'b0, mk("lw_mrdy", 3, SB_ML, 2'b00, -1, 0, 0, 1, 0, -1));
      step(LW, 1'b1, 1'b0, mk("lw_wb", 4, SB_RET, 2'b00, 0, 0, -1, -1, -1, 1));

      // Branch taken then not taken: retires in EXEC
      step(BEQ, 1'b1, 1'b1, mk("beqt_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(BEQ, 1'b1, 1'b1, mk("beqt_d", 1, SB_0, 2'b00, -1, 2, -1, -1, -1, -1));
      step(BEQ, 1'b1, 1'b1, mk("beqt_e", 2, SB_RET0, 2'b00, 1, 2, -1, -1, -1, -1));
      step(BEQ, 1'b1, 1'b0, mk("beqn_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(BEQ, 1'b1, 1'b0, mk("beqn_d", 1, SB_0, 2'b00, -1, 2, -1, -1, -1, -1));
      step(BEQ, 1'b1, 1'b0, mk("beqn_e", 2, SB_RET0, 2'b00, 0, 2, -1, -1, -1, -1));

      run4("jal",   JAL,   3, -1, -1, -1, 2, 1, 1'b1, 1'b0);
      run4("nop",   NOP,   0,  0,  1,  2, 0, 0, 1'b0, 1'b0);
      run4("jalr",  JALR,  0,  0,  1,  0, 2, 2, 1'b1, 1'b1);
      run4("lui",   LUI,   4,  2,  1,  0, 0, 0, 1'b1, 1'b0);
      run4("auipc", AUIPC, 4,  1,  1,  0, 0, 0, 1'b1, 1'b0);
      run4("add",   ADD,  -1,  0,  0,  1, 0, 0, 1'b1, 1'b0);

      // Store, ready on first request: 4-cycle retire from MEM
      step(SW, 1'b1, 1'b0, mk("sw_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(SW, 1'b1, 1'b0, mk("sw_d", 1, SB_0, 2'b00, -1, 1, -1, -1, -1, -1));
      step(SW, 1'b1, 1'b0, mk("sw_e", 2, SB_0, 2'b00, -1, 1, 0, 1, 0, -1));
      step(SW, 1'b1, 1'b0, mk("sw_m", 3, SB_MSR, 2'b00, 0, 1, 0, 1, 0, -1));

      // Fetch ready arrives in exactly the 15th cycle: no error
      for (int k = 0; k < 14; k++)
         step(ADDI, 1'b0, 1'b0, mk("f15_wait", 0, SB_FW, 2'b00, -1, 0, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("f15_rdy", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("f15_d", 1, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("f15_e", 2, SB_0, 2'b00, -1, 0, 0, 1, 2, -1));
      step(ADDI, 1'b1, 1'b0, mk("f15_wb", 4, SB_RET, 2'b00, 0, 0, -1, -1, -1, 0));

      // Fetch timeout: 15 cycles without ready -> bus_err, HALT held
      for (int k = 0; k < 15; k++)
         step(ADDI, 1'b0, 1'b0, mk("fto_wait", 0, SB_FW, 2'b00, -1, 0, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("fto_halt0", 5, SB_0, 2'b01, -1, -1, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("fto_halt1", 5, SB_0, 2'b01, -1, -1, -1, -1, -1, -1));
      rst_n = 1'b0;
      step(ADDI, 1'b1, 1'b0, mk("rst_berr", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      rst_n = 1'b1;

      // Illegal opcode -> HALT with sticky illegal
      step(BAD, 1'b1, 1'b0, mk("ill_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(BAD, 1'b1, 1'b0, mk("ill_d", 1, SB_0, 2'b00, -1, -1, -1, -1, -1, -1));
      step(BAD, 1'b1, 1'b0, mk("ill_halt0", 5, SB_0, 2'b10, -1, -1, -1, -1, -1, -1));
      step(ADDI, 1'b1, 1'b0, mk("ill_halt1", 5, SB_0, 2'b10, -1, -1, -1, -1, -1, -1));
      rst_n = 1'b0;
      step(ADDI, 1'b1, 1'b0, mk("rst_ill", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      rst_n = 1'b1;

      // Reset asserted while a store waits in MEM
      step(SW, 1'b1, 1'b0, mk("swr_f", 0, SB_F, 2'b00, -1, 0, -1, -1, -1, -1));
      step(SW, 1'b1, 1'b0, mk("swr_d", 1, SB_0, 2'b00, -1, 1, -1, -1, -1, -1));
      step(SW, 1'b1, 1'b0, mk("swr_e", 2, SB_0, 2'b00, -1, 1, 0, 1, 0, -1));
      step(SW, 1'b0, 1'b0, mk("swr_mwait", 3, SB_MS, 2'b00, -1, 1, 0, 1, 0, -1));
      rst_n = 1'b0;
      step(SW, 1'b1, 1'b0, mk("swr_rst0", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      step(SW, 1'b1, 1'b0, mk("swr_rst1", 0, SB_0, 2'b00, -1, 0, -1, -1, -1, -1));
      rst_n = 1'b1;
      run4("post_rst", ADDI, 0, 0, 1, 2, 0, 0, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
